ps2_color_ctrl: RTL and testbench

- Keyboard-side producer of the colour-select flags Radd/Gadd/Badd consumed by the VGA pixel-colour stage.
- Receives PS/2 device-to-host frames on the raw ps2_clk/ps2_data pins and decodes make/break scan-code sequences.
- Maintains the red/green/blue/blink selection state, registered in the clk domain.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_frame_rx.sv | 76 +++++++
 rtl/ps2_color_ctrl.sv | 57 +++++
 tb/tb_ps2_color_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes and FSM state encodings shared by the PS/2 receiver and colour decoder.
package ps2_pkg;
   localparam logic [7:0] KEY_R    = 8'h2D;
   localparam logic [7:0] KEY_G    = 8'h34;
   localparam logic [7:0] KEY_B    = 8'h32;
   localparam logic [7:0] KEY_O    = 8'h44;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
   typedef enum logic [1:0] {D_IDLE, D_BRK, D_EXT, D_EXTBRK} dec_state_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the raw PS/2 pins and assembles 11-bit device-to-host frames
// into bytes, flagging parity/stop errors and abandoning stalled frames.
module ps2_frame_rx #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);
   import ps2_pkg::*;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   // [1:0] is the synchroniser, [2] the previous synced value for edge detection
   logic [2:0] clk_sync;
   logic [1:0] dat_sync;
   frame_state_t state, state_nx;
   logic [7:0] shift;
   logic [2:0] bitcnt;
   logic parity;
   logic [TW-1:0] tcnt;
   logic fall, din, timeout, good;
   assign fall    = clk_sync[2] & ~clk_sync[1];
   assign din     = dat_sync[1];
   assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
   assign good    = din & (^shift ^ parity);
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= F_IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (fall)
         case (state)
            F_IDLE:   state_nx = din ? F_IDLE : F_DATA;
            F_DATA:   state_nx = bitcnt == 3'd7 ? F_PARITY : F_DATA;
            F_PARITY: state_nx = F_STOP;
            F_STOP:   state_nx = F_IDLE;
         endcase
      else if (state != F_IDLE && timeout)
         state_nx = F_IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         clk_sync  <= 3'b111;
         dat_sync  <= 2'b11;
         shift     <= '0;
         bitcnt    <= '0;
         parity    <= 1'b0;
         tcnt      <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         dat_sync  <= {dat_sync[0], ps2_data};
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         tcnt      <= (fall || state == F_IDLE || timeout) ? '0 : tcnt + TW'(1);
         if (fall)
            case (state)
               F_IDLE: bitcnt <= '0;
               F_DATA: begin
                  shift  <= {din, shift[7:1]};
                  bitcnt <= bitcnt + 3'd1;
               end
               F_PARITY: parity <= din;
               F_STOP: begin
                  rx_valid  <= good;
                  frame_err <= ~good;
                  if (good) rx_byte <= shift;
               end
            endcase
      end
endmodule

// File: rtl/ps2_color_ctrl.sv
// ps2_color_ctrl: decodes PS/2 make/break sequences into the Radd/Gadd/Badd colour selects.
module ps2_color_ctrl #(
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] KEY_R          = 8'h2D,
   parameter logic [7:0] KEY_G          = 8'h34,
   parameter logic [7:0] KEY_B          = 8'h32,
   parameter logic [7:0] KEY_O          = 8'h44
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       Radd,
   output logic       Gadd,
   output logic       Badd,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);
   import ps2_pkg::*;
   dec_state_t dstate, dstate_nx;
   logic [2:0] rgb, rgb_nx;
   logic o_held, o_held_nx, make;
   ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
   );
   assign {Radd, Gadd, Badd} = rgb;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         dstate <= D_IDLE;
         rgb    <= '0;
         o_held <= 1'b0;
      end else begin
         dstate <= dstate_nx;
         rgb    <= rgb_nx;
         o_held <= o_held_nx;
      end
   always_comb begin
      dstate_nx = dstate;
      if (rx_valid)
         case (dstate)
            D_IDLE:  dstate_nx = rx_byte == SC_BREAK ? D_BRK : rx_byte == SC_EXT ? D_EXT : D_IDLE;
            D_EXT:   dstate_nx = rx_byte == SC_BREAK ? D_EXTBRK : D_IDLE;
            default: dstate_nx = D_IDLE;
         endcase
      make = rx_valid && dstate == D_IDLE && rx_byte != SC_BREAK && rx_byte != SC_EXT;
      // a held O key repeats its make code; only the first one toggles white
      rgb_nx = !make                       ? rgb :
               rx_byte == KEY_R            ? 3'b100 :
               rx_byte == KEY_G            ? 3'b010 :
               rx_byte == KEY_B            ? 3'b001 :
               rx_byte == KEY_O && !o_held ? (rgb == 3'b111 ? 3'b000 : 3'b111) : rgb;
      o_held_nx = make && rx_byte == KEY_O                           ? 1'b1 :
                  rx_valid && dstate == D_BRK && rx_byte == KEY_O    ? 1'b0 : o_held;
   end
endmodule

// File: tb/tb_ps2_color_ctrl.sv
// tb_ps2_color_ctrl: drives PS/2 frames and compares against a byte-sequence reference model.
module tb_ps2_color_ctrl;
   logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1;
   logic Radd, Gadd, Badd, rx_valid, frame_err;
   logic [7:0] rx_byte;
   int checks = 0, errors = 0, vcnt = 0, ecnt = 0, got_v, got_e;
   logic [2:0] m_rgb = 0;
   logic m_held = 0;
   logic [7:0] m_byte = 0;
   logic [7:0] pfx[$];
   ps2_color_ctrl #(.TIMEOUT_CYCLES(300)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .Radd(Radd), .Gadd(Gadd), .Badd(Badd), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (rx_valid) vcnt++;
      if (frame_err) ecnt++;
   end
   function automatic void model_byte(input logic [7:0] b);
      m_byte = b;
      if (pfx.size() == 0) begin
         if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
         else if (b == 8'h2D) m_rgb = 3'b100;
         else if (b == 8'h34) m_rgb = 3'b010;
         else if (b == 8'h32) m_rgb = 3'b001;
         else if (b == 8'h44) begin
            if (!m_held) m_rgb = (m_rgb == 3'b111) ? 3'b000 : 3'b111;
            m_held = 1;
         end
      end else if (pfx.size() == 1 && pfx[0] == 8'hE0 && b == 8'hF0) pfx.push_back(b);
      else begin
         if (pfx.size() == 1 && pfx[0] == 8'hF0 && b == 8'h44) m_held = 0;
         pfx.delete();
      end
   endfunction
   task automatic half();
      repeat (10) @(posedge clk);
      #1;
   endtask
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         half();
         ps2_clk = 0;
         half();
         ps2_clk = 1;
      end
   endtask
   task automatic frame(input logic [7:0] b, input logic bad_par);
      int v0, e0;
      v0 = vcnt;
      e0 = ecnt;
      send_bits({1'b1, ~^b ^ bad_par, b, 1'b0}, 11);
      ps2_data = 1;
      half();
      half();
      got_v = vcnt - v0;
      got_e = ecnt - e0;
      if (!bad_par) model_byte(b);
   endtask
   task automatic do_reset();
      reset = 1;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      m_rgb = 0; m_held = 0; m_byte = 0; pfx.delete();
   endtask
   task automatic test_reset();
      do_reset();
      checks++;
      if ({Radd, Gadd, Badd, rx_byte, rx_valid, frame_err} !== 13'd0) begin
         errors++;
         $display("FAIL reset: got %b expected 0", {Radd, Gadd, Badd, rx_byte, rx_valid, frame_err});
      end
   endtask
   task automatic test_red();
      frame(8'h2D, 0);
      checks++;
      if (got_v !== 1 || got_e !== 0 || rx_byte !== 8'h2D) begin
         errors++;
         $display("FAIL red_frame: valid=%0d err=%0d byte=%h expected 1 0 2d", got_v, got_e, rx_byte);
      end
      checks++;
      if ({Radd, Gadd, Badd} !== 3'b100) begin
         errors++;
         $display("FAIL red_rgb: got %b expected 100", {Radd, Gadd, Badd});
      end
   endtask
   task automatic test_green_break();
      logic [7:0] seq[3] = '{8'h34, 8'hF0, 8'h34};
      foreach (seq[i]) begin
         frame(seq[i], 0);
         checks++;
         if ({Radd, Gadd, Badd} !== 3'b010 || {Radd, Gadd, Badd} !== m_rgb) begin
            errors++;
            $display("FAIL green_break[%0d]: got %b expected 010", i, {Radd, Gadd, Badd});
         end
      end
   endtask
   task automatic test_blink();
      logic [7:0] seq[6] = '{8'h44, 8'h44, 8'h44, 8'hF0, 8'h44, 8'h44};
      logic [2:0] exp_rgb[6] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
      foreach (seq[i]) begin
         frame(seq[i], 0);
         checks++;
         if ({Radd, Gadd, Badd} !== exp_rgb[i] || m_rgb !== exp_rgb[i]) begin
            errors++;
            $display("FAIL blink[%0d]: got %b model %b expected %b", i, {Radd, Gadd, Badd}, m_rgb, exp_rgb[i]);
         end
      end
   endtask
   task automatic test_parity_err();
      frame(8'h32, 1);
      checks++;
      if (got_e !== 1 || got_v !== 0 || rx_byte !== 8'h44 || {Radd, Gadd, Badd} !== 3'b000) begin
         errors++;
         $display("FAIL parity_err: err=%0d valid=%0d byte=%h rgb=%b expected 1 0 44 000",
                  got_e, got_v, rx_byte, {Radd, Gadd, Badd});
      end
      frame(8'h32, 0);
      checks++;
      if (got_v !== 1 || {Radd, Gadd, Badd} !== 3'b001) begin
         errors++;
         $display("FAIL parity_recover: valid=%0d rgb=%b expected 1 001", got_v, {Radd, Gadd, Badd});
      end
   endtask
   task automatic test_timeout();
      int v0, e0;
      v0 = vcnt;
      e0 = ecnt;
      send_bits(11'b000_1011_0100, 5);
      ps2_data = 1;
      repeat (400) @(posedge clk);
      #1;
      checks++;
      if (vcnt != v0 || ecnt != e0) begin
         errors++;
         $display("FAIL timeout_silent: valid=%0d err=%0d expected 0 0", vcnt - v0, ecnt - e0);
      end
      frame(8'h2D, 0);
      checks++;
      if (got_v !== 1 || rx_byte !== 8'h2D || {Radd, Gadd, Badd} !== 3'b100) begin
         errors++;
         $display("FAIL timeout_recover: valid=%0d byte=%h rgb=%b expected 1 2d 100", got_v, rx_byte, {Radd, Gadd, Badd});
      end
   endtask
   task automatic test_ext();
      logic [7:0] seq[5] = '{8'hE0, 8'h2D, 8'hE0, 8'hF0, 8'h2D};
      frame(8'h32, 0);
      foreach (seq[i]) begin
         frame(seq[i], 0);
         checks++;
         if ({Radd, Gadd, Badd} !== 3'b001) begin
            errors++;
            $display("FAIL ext[%0d]: got %b expected 001", i, {Radd, Gadd, Badd});
         end
      end
   endtask
   task automatic test_random();
      logic [7:0] tbl[8] = '{8'h2D, 8'h34, 8'h32, 8'h44, 8'hF0, 8'hE0, 8'h1C, 8'h44};
      for (int i = 0; i < 30; i++) begin
         logic [7:0] b;
         logic bad;
         b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 7)];
         bad = $urandom_range(0, 6) == 0;
         frame(b, bad);
         checks++;
         if (got_v !== int'(!bad) || got_e !== int'(bad) || rx_byte !== m_byte || {Radd, Gadd, Badd} !== m_rgb) begin
            errors++;
            $display("FAIL random[%0d] byte %h bad %0d: valid=%0d err=%0d rx=%h rgb=%b expected rx=%h rgb=%b",
                     i, b, bad, got_v, got_e, rx_byte, {Radd, Gadd, Badd}, m_byte, m_rgb);
         end
      end
   endtask
   task automatic test_reset_midframe();
      frame(8'h34, 0);
      send_bits(11'b000_1011_0100, 5);
      @(posedge clk);
      #3 reset = 1;
      #1;
      checks++;
      if ({Radd, Gadd, Badd, rx_byte, rx_valid, frame_err} !== 13'd0) begin
         errors++;
         $display("FAIL reset_midframe: got %b expected 0", {Radd, Gadd, Badd, rx_byte, rx_valid, frame_err});
      end
      ps2_data = 1;
      do_reset();
      frame(8'h32, 0);
      checks++;
      if (got_v !== 1 || rx_byte !== 8'h32 || {Radd, Gadd, Badd} !== 3'b001) begin
         errors++;
         $display("FAIL reset_recover: valid=%0d byte=%h rgb=%b expected 1 32 001", got_v, rx_byte, {Radd, Gadd, Badd});
      end
   endtask
   initial begin
      test_reset();
      test_red();
      test_green_break();
      test_blink();
      test_parity_err();
      test_timeout();
      test_ext();
      test_random();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
